// File: rtl/counter_gen_pkg.sv
// Shared types and window constants for the counter_gen status-strobe sequencer.
// Each window is an inclusive [LO, HI] range of the 16-phase counter during
// which the named strobe is high.
package counter_gen_pkg;

  typedef logic [3:0] phase_t;

  // Registered strobe image; one field per output port.
  typedef struct packed {
    // group 1
    logic rt1;
    logic rdy1;
    logic start1;
    logic endd1;
    logic help1;
    // group 2
    logic er2;
    // group 3
    logic er3;
    logic rdy3;
    // group 4
    logic rdy4;
    logic start4;
    // group 5
    logic endd5;
    logic stop5;
    logic er5;
    logic rdy5;
    logic start5;
    // group 6
    logic endd6;
    logic stop6;
    logic er6;
    logic rdy6;
    // group 7
    logic endd7;
    logic start7;
    logic status_valid7;
    logic instartsv7;
    // group 8
    logic rt8;
    logic enable8;
    // group 9
    logic rdy9;
    logic start9;
    logic interrupt9;
    // group 10
    logic ack10;
    logic req10;
  } status_t;

  // Group 1: rt1/help1 overlap only in phases where rdy1/start1/endd1 are idle.
  localparam phase_t RDY1_LO   = 4'd1;
  localparam phase_t RDY1_HI   = 4'd1;
  localparam phase_t START1_LO = 4'd2;
  localparam phase_t START1_HI = 4'd2;
  localparam phase_t ENDD1_LO  = 4'd5;
  localparam phase_t ENDD1_HI  = 4'd5;
  localparam phase_t HELP1A_LO = 4'd4;
  localparam phase_t HELP1A_HI = 4'd7;
  localparam phase_t HELP1B_LO = 4'd12;
  localparam phase_t HELP1B_HI = 4'd15;
  localparam phase_t RT1_LO    = 4'd8;
  localparam phase_t RT1_HI    = 4'd15;

  // Group 2: er2 lasts exactly three cycles.
  localparam phase_t ER2_LO = 4'd4;
  localparam phase_t ER2_HI = 4'd6;

  // Group 3: er3 and rdy3 overlap in a single phase only.
  localparam phase_t ER3_LO  = 4'd2;
  localparam phase_t ER3_HI  = 4'd5;
  localparam phase_t RDY3_LO = 4'd5;
  localparam phase_t RDY3_HI = 4'd7;

  // Group 4: rdy4 nested inside start4.
  localparam phase_t START4_LO = 4'd8;
  localparam phase_t START4_HI = 4'd9;
  localparam phase_t RDY4_LO   = 4'd9;
  localparam phase_t RDY4_HI   = 4'd9;

  // Group 5: rdy5 stays away from the cycle after any termination strobe.
  localparam phase_t START5_LO = 4'd1;
  localparam phase_t START5_HI = 4'd1;
  localparam phase_t RDY5_LO   = 4'd2;
  localparam phase_t RDY5_HI   = 4'd3;
  localparam phase_t ENDD5_LO  = 4'd6;
  localparam phase_t ENDD5_HI  = 4'd6;
  localparam phase_t STOP5_LO  = 4'd10;
  localparam phase_t STOP5_HI  = 4'd10;
  localparam phase_t ER5_LO    = 4'd13;
  localparam phase_t ER5_HI    = 4'd13;

  // Group 6: every termination strobe sits inside the rdy6 window.
  localparam phase_t RDY6_LO  = 4'd4;
  localparam phase_t RDY6_HI  = 4'd11;
  localparam phase_t ENDD6_LO = 4'd6;
  localparam phase_t ENDD6_HI = 4'd6;
  localparam phase_t STOP6_LO = 4'd8;
  localparam phase_t STOP6_HI = 4'd8;
  localparam phase_t ER6_LO   = 4'd10;
  localparam phase_t ER6_HI   = 4'd10;

  // Group 7: endd7 is disjoint from start7 and status_valid7.
  localparam phase_t START7_LO = 4'd1;
  localparam phase_t START7_HI = 4'd1;
  localparam phase_t SV7_LO    = 4'd2;
  localparam phase_t SV7_HI    = 4'd4;
  localparam phase_t ISSV7_LO  = 4'd1;
  localparam phase_t ISSV7_HI  = 4'd4;
  localparam phase_t ENDD7_LO  = 4'd7;
  localparam phase_t ENDD7_HI  = 4'd7;

  // Group 8: enable8 begins three phases after rt8.
  localparam phase_t RT8_LO     = 4'd3;
  localparam phase_t RT8_HI     = 4'd3;
  localparam phase_t ENABLE8_LO = 4'd6;
  localparam phase_t ENABLE8_HI = 4'd9;

  // Group 9: the phase after interrupt9 is quiet.
  localparam phase_t START9_LO = 4'd1;
  localparam phase_t START9_HI = 4'd1;
  localparam phase_t RDY9_LO   = 4'd2;
  localparam phase_t RDY9_HI   = 4'd5;
  localparam phase_t INT9_LO   = 4'd12;
  localparam phase_t INT9_HI   = 4'd12;

  // Group 10: ack10 trails req10 by five phases.
  localparam phase_t REQ10_LO = 4'd2;
  localparam phase_t REQ10_HI = 4'd2;
  localparam phase_t ACK10_LO = 4'd7;
  localparam phase_t ACK10_HI = 4'd7;

endpackage

// File: rtl/phase_window.sv
// Combinational phase-window decoder: in_win is high when LO <= phase <= HI.
module phase_window
  import counter_gen_pkg::*;
#(
  parameter phase_t LO = 4'd0,
  parameter phase_t HI = 4'd0
) (
  input  logic [3:0] phase,
  output logic       in_win
);

  // Offset-from-LO form: a single unsigned compare that stays meaningful for
  // windows touching either end of the range (no constant-true comparisons).
  localparam phase_t SPAN = HI - LO;

  phase_t offset;

  // Range check relative to the window start.
  always_comb begin
    offset = phase - LO;
    in_win = (offset <= SPAN);
  end

endmodule

// File: rtl/counter_gen.sv
// counter_gen: free-running 16-phase sequencer driving ten groups of status
// strobes. Every strobe is registered and equals the window decode of the
// current phase, because it is loaded from the decode of the next phase.
module counter_gen
  import counter_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic rt1,
  output logic rdy1,
  output logic start1,
  output logic endd1,
  output logic help1,
  output logic er2,
  output logic er3,
  output logic rdy3,
  output logic rdy4,
  output logic start4,
  output logic endd5,
  output logic stop5,
  output logic er5,
  output logic rdy5,
  output logic start5,
  output logic endd6,
  output logic stop6,
  output logic er6,
  output logic rdy6,
  output logic endd7,
  output logic start7,
  output logic status_valid7,
  output logic instartsv7,
  output logic rt8,
  output logic enable8,
  output logic rdy9,
  output logic start9,
  output logic interrupt9,
  output logic ack10,
  output logic req10
);

  phase_t  phase;
  phase_t  next_phase;
  status_t dec;
  status_t status_q;
  logic    help1_a;
  logic    help1_b;

  // Next phase wraps 15 -> 0 through natural 4-bit overflow.
  always_comb begin
    next_phase = phase + phase_t'(1);
  end

  // ---------------------------------------------------------------- group 1
  phase_window #(.LO(RDY1_LO),   .HI(RDY1_HI))   u_rdy1   (.phase(next_phase), .in_win(dec.rdy1));
  phase_window #(.LO(START1_LO), .HI(START1_HI)) u_start1 (.phase(next_phase), .in_win(dec.start1));
  phase_window #(.LO(ENDD1_LO),  .HI(ENDD1_HI))  u_endd1  (.phase(next_phase), .in_win(dec.endd1));
  phase_window #(.LO(HELP1A_LO), .HI(HELP1A_HI)) u_help1a (.phase(next_phase), .in_win(help1_a));
  phase_window #(.LO(HELP1B_LO), .HI(HELP1B_HI)) u_help1b (.phase(next_phase), .in_win(help1_b));
  phase_window #(.LO(RT1_LO),    .HI(RT1_HI))    u_rt1    (.phase(next_phase), .in_win(dec.rt1));

  // help1 has two disjoint windows.
  always_comb begin
    dec.help1 = help1_a | help1_b;
  end

  // ---------------------------------------------------------------- group 2
  phase_window #(.LO(ER2_LO), .HI(ER2_HI)) u_er2 (.phase(next_phase), .in_win(dec.er2));

  // ---------------------------------------------------------------- group 3
  phase_window #(.LO(ER3_LO),  .HI(ER3_HI))  u_er3  (.phase(next_phase), .in_win(dec.er3));
  phase_window #(.LO(RDY3_LO), .HI(RDY3_HI)) u_rdy3 (.phase(next_phase), .in_win(dec.rdy3));

  // ---------------------------------------------------------------- group 4
  phase_window #(.LO(RDY4_LO),   .HI(RDY4_HI))   u_rdy4   (.phase(next_phase), .in_win(dec.rdy4));
  phase_window #(.LO(START4_LO), .HI(START4_HI)) u_start4 (.phase(next_phase), .in_win(dec.start4));

  // ---------------------------------------------------------------- group 5
  phase_window #(.LO(ENDD5_LO),  .HI(ENDD5_HI))  u_endd5  (.phase(next_phase), .in_win(dec.endd5));
  phase_window #(.LO(STOP5_LO),  .HI(STOP5_HI))  u_stop5  (.phase(next_phase), .in_win(dec.stop5));
  phase_window #(.LO(ER5_LO),    .HI(ER5_HI))    u_er5    (.phase(next_phase), .in_win(dec.er5));
  phase_window #(.LO(RDY5_LO),   .HI(RDY5_HI))   u_rdy5   (.phase(next_phase), .in_win(dec.rdy5));
  phase_window #(.LO(START5_LO), .HI(START5_HI)) u_start5 (.phase(next_phase), .in_win(dec.start5));

  // ---------------------------------------------------------------- group 6
  phase_window #(.LO(ENDD6_LO), .HI(ENDD6_HI)) u_endd6 (.phase(next_phase), .in_win(dec.endd6));
  phase_window #(.LO(STOP6_LO), .HI(STOP6_HI)) u_stop6 (.phase(next_phase), .in_win(dec.stop6));
  phase_window #(.LO(ER6_LO),   .HI(ER6_HI))   u_er6   (.phase(next_phase), .in_win(dec.er6));
  phase_window #(.LO(RDY6_LO),  .HI(RDY6_HI))  u_rdy6  (.phase(next_phase), .in_win(dec.rdy6));

  // ---------------------------------------------------------------- group 7
  phase_window #(.LO(ENDD7_LO),  .HI(ENDD7_HI))  u_endd7  (.phase(next_phase), .in_win(dec.endd7));
  phase_window #(.LO(START7_LO), .HI(START7_HI)) u_start7 (.phase(next_phase), .in_win(dec.start7));
  phase_window #(.LO(SV7_LO),    .HI(SV7_HI))    u_sv7    (.phase(next_phase), .in_win(dec.status_valid7));
  phase_window #(.LO(ISSV7_LO),  .HI(ISSV7_HI))  u_issv7  (.phase(next_phase), .in_win(dec.instartsv7));

  // ---------------------------------------------------------------- group 8
  phase_window #(.LO(RT8_LO),     .HI(RT8_HI))     u_rt8     (.phase(next_phase), .in_win(dec.rt8));
  phase_window #(.LO(ENABLE8_LO), .HI(ENABLE8_HI)) u_enable8 (.phase(next_phase), .in_win(dec.enable8));

  // ---------------------------------------------------------------- group 9
  phase_window #(.LO(RDY9_LO),   .HI(RDY9_HI))   u_rdy9   (.phase(next_phase), .in_win(dec.rdy9));
  phase_window #(.LO(START9_LO), .HI(START9_HI)) u_start9 (.phase(next_phase), .in_win(dec.start9));
  phase_window #(.LO(INT9_LO),   .HI(INT9_HI))   u_int9   (.phase(next_phase), .in_win(dec.interrupt9));

  // --------------------------------------------------------------- group 10
  phase_window #(.LO(ACK10_LO), .HI(ACK10_HI)) u_ack10 (.phase(next_phase), .in_win(dec.ack10));
  phase_window #(.LO(REQ10_LO), .HI(REQ10_HI)) u_req10 (.phase(next_phase), .in_win(dec.req10));

  // Phase counter and strobe registers; reset restarts the schedule at phase 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset here is synchronous, so rst only acts
  // on a rising clk edge and is deliberately absent from the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase    <= '0;
      status_q <= '0;
    end else begin
      phase    <= next_phase;
      status_q <= dec;
    end
  end

  // Fan the registered image out to the individual ports.
  always_comb begin
    rt1           = status_q.rt1;
    rdy1          = status_q.rdy1;
    start1        = status_q.start1;
    endd1         = status_q.endd1;
    help1         = status_q.help1;
    er2           = status_q.er2;
    er3           = status_q.er3;
    rdy3          = status_q.rdy3;
    rdy4          = status_q.rdy4;
    start4        = status_q.start4;
    endd5         = status_q.endd5;
    stop5         = status_q.stop5;
    er5           = status_q.er5;
    rdy5          = status_q.rdy5;
    start5        = status_q.start5;
    endd6         = status_q.endd6;
    stop6         = status_q.stop6;
    er6           = status_q.er6;
    rdy6          = status_q.rdy6;
    endd7         = status_q.endd7;
    start7        = status_q.start7;
    status_valid7 = status_q.status_valid7;
    instartsv7    = status_q.instartsv7;
    rt8           = status_q.rt8;
    enable8       = status_q.enable8;
    rdy9          = status_q.rdy9;
    start9        = status_q.start9;
    interrupt9    = status_q.interrupt9;
    ack10         = status_q.ack10;
    req10         = status_q.req10;
  end

endmodule

// File: tb/tb_counter_gen.sv
// Self-checking bench for counter_gen: a phase model pushes the expected
// strobe vector into a scoreboard after each clock edge, and the observed
// vector is popped and compared on the following falling edge.
module tb_counter_gen;

  logic clk;
  logic rst;
  logic rt1, rdy1, start1, endd1, help1;
  logic er2;
  logic er3, rdy3;
  logic rdy4, start4;
  logic endd5, stop5, er5, rdy5, start5;
  logic endd6, stop6, er6, rdy6;
  logic endd7, start7, status_valid7, instartsv7;
  logic rt8, enable8;
  logic rdy9, start9, interrupt9;
  logic ack10, req10;

  int total;
  int bad;
  int mp;            // model phase
  int req_age;       // cycles since the model last saw req10, -1 when none pending
  logic [29:0] sb_q[$];
  logic [29:0] dut_vec;

  counter_gen dut (
    .clk(clk), .rst(rst),
    .rt1(rt1), .rdy1(rdy1), .start1(start1), .endd1(endd1), .help1(help1),
    .er2(er2),
    .er3(er3), .rdy3(rdy3),
    .rdy4(rdy4), .start4(start4),
    .endd5(endd5), .stop5(stop5), .er5(er5), .rdy5(rdy5), .start5(start5),
    .endd6(endd6), .stop6(stop6), .er6(er6), .rdy6(rdy6),
    .endd7(endd7), .start7(start7), .status_valid7(status_valid7), .instartsv7(instartsv7),
    .rt8(rt8), .enable8(enable8),
    .rdy9(rdy9), .start9(start9), .interrupt9(interrupt9),
    .ack10(ack10), .req10(req10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_vec = {req10, ack10, interrupt9, start9, rdy9, enable8, rt8,
                    instartsv7, status_valid7, start7, endd7,
                    rdy6, er6, stop6, endd6,
                    start5, rdy5, er5, stop5, endd5,
                    start4, rdy4, rdy3, er3, er2,
                    help1, endd1, start1, rdy1, rt1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (model phase %0d, t=%0t)", tag, got, exp, mp, $time);
    end
  endtask

  // Window table written straight from the schedule, same bit order as dut_vec.
  function automatic logic [29:0] model(input int p);
    logic [29:0] v;
    v = '0;
    v[0]  = (p >= 8);                          // rt1
    v[1]  = (p == 1);                          // rdy1
    v[2]  = (p == 2);                          // start1
    v[3]  = (p == 5);                          // endd1
    v[4]  = (p >= 4 && p <= 7) || (p >= 12);   // help1
    v[5]  = (p >= 4 && p <= 6);                // er2
    v[6]  = (p >= 2 && p <= 5);                // er3
    v[7]  = (p >= 5 && p <= 7);                // rdy3
    v[8]  = (p == 9);                          // rdy4
    v[9]  = (p == 8 || p == 9);                // start4
    v[10] = (p == 6);                          // endd5
    v[11] = (p == 10);                         // stop5
    v[12] = (p == 13);                         // er5
    v[13] = (p == 2 || p == 3);                // rdy5
    v[14] = (p == 1);                          // start5
    v[15] = (p == 6);                          // endd6
    v[16] = (p == 8);                          // stop6
    v[17] = (p == 10);                         // er6
    v[18] = (p >= 4 && p <= 11);               // rdy6
    v[19] = (p == 7);                          // endd7
    v[20] = (p == 1);                          // start7
    v[21] = (p >= 2 && p <= 4);                // status_valid7
    v[22] = (p >= 1 && p <= 4);                // instartsv7
    v[23] = (p == 3);                          // rt8
    v[24] = (p >= 6 && p <= 9);                // enable8
    v[25] = (p >= 2 && p <= 5);                // rdy9
    v[26] = (p == 1);                          // start9
    v[27] = (p == 12);                         // interrupt9
    v[28] = (p == 7);                          // ack10
    v[29] = (p == 2);                          // req10
    return v;
  endfunction

  // One clock: advance the model at the edge, push the expectation, then pop
  // and compare at the falling edge, plus the targeted schedule checks.
  task automatic cycle();
    logic [29:0] exp_v;
    @(posedge clk);
    if (!rst) begin
      mp      = 0;
      req_age = -1;
    end else begin
      mp = (mp + 1) % 16;
      if (req_age >= 0) req_age++;
    end
    sb_q.push_back(model(mp));
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      exp_v = sb_q.pop_front();
      check("vec", {2'b0, dut_vec}, {2'b0, exp_v});
    end
    if (rst && mp == 9) begin
      check("rdy4_p9", {31'b0, rdy4}, 32'd1);
      check("start4_p9", {31'b0, start4}, 32'd1);
    end
    if (rst && mp == 8) begin
      check("rdy4_p8", {31'b0, rdy4}, 32'd0);
      check("start4_p8", {31'b0, start4}, 32'd1);
    end
    if (rst && mp == 7) check("er2_off_p7", {31'b0, er2}, 32'd0);
    if (rst && mp == 12) begin
      check("rt1_help1_p12", {30'b0, rt1, help1}, 32'd3);
      check("g1_excl_p12", {29'b0, rdy1, start1, endd1}, 32'd0);
    end
    if (rst && (mp == 7 || mp == 11 || mp == 14)) check("rdy5_after_term", {31'b0, rdy5}, 32'd0);
    if (rst && mp == 0) check("wrap_zero", {2'b0, dut_vec}, 32'd0);
    if (req_age >= 1 && req_age <= 4) check("ack10_early", {31'b0, ack10}, 32'd0);
    if (req_age == 5) begin
      check("ack10_at_5", {31'b0, ack10}, 32'd1);
      req_age = -1;
    end
    if (rst && mp == 2) req_age = 0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    mp      = 0;
    req_age = -1;
    rst     = 1'b0;

    // Reset held for three edges: everything low.
    repeat (3) begin
      cycle();
      check("reset_zero", {2'b0, dut_vec}, 32'd0);
    end

    // First released edge lands on phase 1.
    rst = 1'b1;
    cycle();
    check("first_p1_starts", {28'b0, rdy1, start5, start7, start9}, 32'hF);

    // Long free run across two wraps.
    repeat (40) cycle();

    // Advance to phase 5, then abort with a one-edge reset.
    for (int i = 0; i < 16 && mp != 5; i++) cycle();
    check("at_phase5", mp, 32'd5);
    rst = 1'b0;
    cycle();
    check("abort_zero", {2'b0, dut_vec}, 32'd0);
    rst = 1'b1;
    cycle();
    check("resume_p1", {28'b0, rdy1, start5, start7, start9}, 32'hF);
    cycle();
    check("no_stale_ack10", {31'b0, ack10}, 32'd0);

    // Another full period after the abort, including the new req/ack pair.
    repeat (18) cycle();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
